// File: rtl/spram_lane_pkg.sv
// Shared defaults for the single-port RAM lane.
// The lane takes its widths positionally from its parent. These constants only
// provide defaults for the bus interface so that both sides agree.
package spram_lane_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultAddrWidth = 21;

endpackage

// File: rtl/spram_lane_if.sv
// Bus bundle for one single-port RAM lane: shared address, write data, write
// enable and registered read data.
//   master : drives addr/din/we and receives dout (parent wrapper or bench)
//   slave  : the RAM side
interface spram_lane_if
    import spram_lane_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
);

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic                  we;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output addr,
        output din,
        output we,
        input  dout
    );

    modport slave (
        input  addr,
        input  din,
        input  we,
        output dout
    );

endinterface

// File: rtl/spram_lane.sv
// Single-port synchronous RAM lane, DATA_WIDTH bits wide, 2**ADDR_WIDTH deep.
// Sixteen of these side by side make up the 128-bit simulation main memory.
//
// Ports:
//   PortAClk          clock, all state changes on the rising edge
//   PortARst          synchronous active-high reset (clears output only)
//   PortAAddr         entry address for both read and write
//   PortADataIn       write data
//   PortAWriteEnable  1 = write this cycle, 0 = read this cycle
//   PortADataOut      registered read data, 1-cycle latency
//
// The storage array is named mem and is accessed hierarchically by backdoor
// load/poke/peek utilities, so its name and shape must not change.
module spram_lane #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 21
) (
    input  logic                  PortAClk,
    input  logic                  PortARst,
    input  logic [ADDR_WIDTH-1:0] PortAAddr,
    input  logic [DATA_WIDTH-1:0] PortADataIn,
    input  logic                  PortAWriteEnable,
    output logic [DATA_WIDTH-1:0] PortADataOut
);

    localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;

    reg [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    logic [DATA_WIDTH-1:0] dout_q;

    // Array and output register share one clocked process so the read is a
    // true synchronous read. Reset clears only the output and blocks writes;
    // mem is left alone so a preload done before or during reset survives.
    // A write leaves the output untouched (no write-through).
    always_ff @(posedge PortAClk) begin
        if (PortARst) begin
            dout_q <= '0;
        end else if (PortAWriteEnable) begin
            mem[PortAAddr] <= PortADataIn;
        end else begin
            dout_q <= mem[PortAAddr];
        end
    end

    assign PortADataOut = dout_q;

endmodule

// File: tb/tb_spram_lane.sv
// Self-checking bench for spram_lane: a constant vector table plus a few
// hand-written sequences, all checked through an expected-value queue.
module tb_spram_lane;

    localparam int unsigned Dw = 8;
    localparam int unsigned Aw = 21;
    localparam logic [Aw-1:0] AddrMax = 21'h1FFFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    spram_lane_if #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw)) bus ();

    spram_lane #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw)) dut (
        .PortAClk         (clk),
        .PortARst         (rst),
        .PortAAddr        (bus.addr),
        .PortADataIn      (bus.din),
        .PortAWriteEnable (bus.we),
        .PortADataOut     (bus.dout)
    );

    typedef struct {
        logic          rst;
        logic          we;
        logic [Aw-1:0] addr;
        logic [Dw-1:0] din;
        logic [Dw-1:0] exp;
        string         name;
    } vec_t;

    typedef struct {
        logic [Dw-1:0] exp;
        string         name;
    } sb_t;

    localparam int NumVec = 21;
    vec_t vecs [NumVec];
    sb_t  sb_q [$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [Dw-1:0] act,
                         input logic [Dw-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, queue the expected output, compare after the edge.
    task automatic cycle(input logic r, input logic w, input logic [Aw-1:0] a,
                         input logic [Dw-1:0] d, input logic [Dw-1:0] e,
                         input string name);
        sb_t ent;
        sb_t got;
        @(negedge clk);
        rst      = r;
        bus.we   = w;
        bus.addr = a;
        bus.din  = d;
        ent.exp  = e;
        ent.name = name;
        sb_q.push_back(ent);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", name, bus.dout);
        end else begin
            got = sb_q.pop_front();
            check(got.name, bus.dout, got.exp);
        end
    endtask

    initial begin
        //           rst   we    addr         din    exp    name
        vecs[0]  = '{1'b1, 1'b1, 21'h000005, 8'h00, 8'h00, "rst_c1_we_hi"};
        vecs[1]  = '{1'b1, 1'b1, 21'h000005, 8'h00, 8'h00, "rst_c2_we_hi"};
        vecs[2]  = '{1'b0, 1'b0, 21'h000005, 8'h00, 8'hA5, "read_preload"};
        vecs[3]  = '{1'b0, 1'b1, 21'h000010, 8'h3C, 8'hA5, "write_holds"};
        vecs[4]  = '{1'b0, 1'b0, 21'h000010, 8'h00, 8'h3C, "read_3c"};
        vecs[5]  = '{1'b0, 1'b0, 21'h000010, 8'h00, 8'h3C, "hold1"};
        vecs[6]  = '{1'b0, 1'b0, 21'h000010, 8'h00, 8'h3C, "hold2"};
        vecs[7]  = '{1'b0, 1'b0, 21'h000010, 8'h00, 8'h3C, "hold3"};
        vecs[8]  = '{1'b0, 1'b0, 21'h000010, 8'h00, 8'h3C, "hold4"};
        vecs[9]  = '{1'b0, 1'b0, 21'h000010, 8'h00, 8'h3C, "hold5"};
        vecs[10] = '{1'b0, 1'b1, 21'h000010, 8'h77, 8'h3C, "write77_holds"};
        vecs[11] = '{1'b0, 1'b0, 21'h000010, 8'h00, 8'h77, "read_77"};
        vecs[12] = '{1'b0, 1'b1, 21'h000020, 8'h11, 8'h77, "wr_20"};
        vecs[13] = '{1'b0, 1'b1, 21'h000021, 8'h22, 8'h77, "wr_21"};
        vecs[14] = '{1'b0, 1'b0, 21'h000020, 8'h00, 8'h11, "rd_20"};
        vecs[15] = '{1'b0, 1'b0, 21'h000021, 8'h00, 8'h22, "rd_21"};
        vecs[16] = '{1'b0, 1'b1, 21'h000000, 8'hFF, 8'h22, "wr_addr0"};
        vecs[17] = '{1'b0, 1'b1, AddrMax,    8'h01, 8'h22, "wr_addrmax"};
        vecs[18] = '{1'b0, 1'b0, 21'h000000, 8'h00, 8'hFF, "rd_addr0"};
        vecs[19] = '{1'b0, 1'b0, AddrMax,    8'h00, 8'h01, "rd_addrmax"};
        vecs[20] = '{1'b0, 1'b1, 21'h004000, 8'h5A, 8'h01, "wr_4000"};

        bus.we   = 1'b0;
        bus.addr = '0;
        bus.din  = '0;

        // Preload before reset; reset must not clear it.
        dut.mem[5] = 8'hA5;

        for (int i = 0; i < NumVec; i++) begin
            cycle(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp,
                  vecs[i].name);
            if (i == 1) check("mem5_survives_rst", dut.mem[5], 8'hA5);
        end

        // Backdoor peek of a port write.
        check("peek_4000", dut.mem[21'h004000], 8'h5A);

        // Back-to-back write then read of the same address.
        cycle(1'b0, 1'b1, 21'h000040, 8'h9E, 8'h01, "wr_40");
        cycle(1'b0, 1'b0, 21'h000040, 8'h00, 8'h9E, "rd_40_next");

        // Backdoor poke is visible at the next port read.
        @(negedge clk);
        dut.mem[21'h000030] = 8'hC3;
        cycle(1'b0, 1'b0, 21'h000030, 8'h00, 8'hC3, "rd_poke");

        // Reset mid-stream with write enable high: output clears, write blocked.
        cycle(1'b1, 1'b1, 21'h004000, 8'hEE, 8'h00, "rst_mid");
        cycle(1'b0, 1'b0, 21'h004000, 8'h00, 8'h5A, "rd_after_rst");

        // Write at the top address must not alias address 0.
        cycle(1'b0, 1'b1, AddrMax,    8'h6B, 8'h5A, "wr_max_again");
        cycle(1'b0, 1'b0, 21'h000000, 8'h00, 8'hFF, "rd0_no_alias");

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
